// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the TX frame scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Wide enough for any underrun timeout up to 255 cycles.
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant_c,
  output logic               grant_valid_c
);

  int unsigned idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_c       = '0;
    grant_valid_c = 1'b0;
    idx           = 0;
    for (int unsigned k = NUM_SRC; k > 0; k--) begin
      idx = (32'(last_grant) + k) % NUM_SRC;
      if (req[IDX_W'(idx)]) begin
        grant_c       = IDX_W'(idx);
        grant_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Frame-granular round-robin drain of FWFT FIFO read ports into one stream,
// with mid-frame underrun abort and flush of the remainder of the frame.
module tx_frame_scheduler
  import tx_sched_pkg::*;
#(
  parameter  int unsigned NUM_SRC          = 4,
  parameter  int unsigned DATA_WIDTH       = 8,
  parameter  int unsigned UNDERRUN_TIMEOUT = 16,
  localparam int unsigned IDX_W            = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_SRC-1:0]            src_empty,
  input  logic [NUM_SRC-1:0]            src_almost_empty,
  input  logic [NUM_SRC-1:0]            src_frame_ready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_last,
  output logic [NUM_SRC-1:0]            src_rd,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  output logic                          m_tuser,
  output logic [IDX_W-1:0]              m_tsrc,
  input  logic                          m_tready,
  output logic                          underrun_pulse
);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        pick;
  logic                    pick_valid;
  logic [NUM_SRC-1:0]      eligible;
  logic [DATA_WIDTH-1:0]   data_arr [NUM_SRC];
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_empty, sel_last;
  logic                    load_ok, timeout, pop, load_word, abort;
  logic                    tvalid_d, tlast_d, tuser_d, pulse_d;
  logic [DATA_WIDTH-1:0]   tdata_d;
  logic [IDX_W-1:0]        tsrc_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign data_arr[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // A source may start a frame only with a full frame or a comfortable backlog.
  assign eligible  = ~src_empty & (src_frame_ready | ~src_almost_empty);
  assign sel_data  = data_arr[grant_q];
  assign sel_empty = src_empty[grant_q];
  assign sel_last  = src_last[grant_q];
  assign load_ok   = !m_tvalid || m_tready;
  assign timeout   = (cnt_q == CNT_W'(UNDERRUN_TIMEOUT));

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req           (eligible),
    .last_grant    (last_grant_q),
    .grant_c       (pick),
    .grant_valid_c (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    load_word    = 1'b0;
    abort        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d      = pick;
          last_grant_d = pick;
          cnt_d        = '0;
          state_d      = XFER;
        end
      end
      XFER: begin
        // The abort word outranks a pop that becomes possible in the same cycle.
        if (timeout) begin
          if (load_ok) begin
            abort   = 1'b1;
            state_d = DRAIN;
          end
        end else if (!sel_empty) begin
          if (load_ok) begin
            pop       = 1'b1;
            load_word = 1'b1;
            cnt_d     = '0;
            if (sel_last) state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (!sel_empty) begin
          pop = 1'b1;
          if (sel_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tvalid_d = m_tvalid;
    tdata_d  = m_tdata;
    tlast_d  = m_tlast;
    tuser_d  = m_tuser;
    tsrc_d   = m_tsrc;
    pulse_d  = abort;
    if (load_word) begin
      tvalid_d = 1'b1;
      tdata_d  = sel_data;
      tlast_d  = sel_last;
      tuser_d  = 1'b0;
      tsrc_d   = grant_q;
    end else if (abort) begin
      tvalid_d = 1'b1;
      tdata_d  = '0;
      tlast_d  = 1'b1;
      tuser_d  = 1'b1;
      tsrc_d   = grant_q;
    end else if (m_tready) begin
      tvalid_d = 1'b0;
    end
  end

  assign src_rd = (reset_n && pop) ? (NUM_SRC'(1) << grant_q) : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      last_grant_q   <= IDX_W'(NUM_SRC - 1);
      cnt_q          <= '0;
      m_tvalid       <= 1'b0;
      m_tdata        <= '0;
      m_tlast        <= 1'b0;
      m_tuser        <= 1'b0;
      m_tsrc         <= '0;
      underrun_pulse <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      m_tvalid       <= tvalid_d;
      m_tdata        <= tdata_d;
      m_tlast        <= tlast_d;
      m_tuser        <= tuser_d;
      m_tsrc         <= tsrc_d;
      underrun_pulse <= pulse_d;
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with a queue-based FWFT source model.
module tb_tx_frame_scheduler;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NS-1:0]    src_empty, src_almost_empty, src_frame_ready, src_last, src_rd;
  logic [NS*DW-1:0] src_data;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid, m_tlast, m_tuser, m_tready, underrun_pulse;
  logic [1:0]       m_tsrc;

  always #5 clk = ~clk;

  tx_frame_scheduler #(.NUM_SRC(NS), .DATA_WIDTH(DW), .UNDERRUN_TIMEOUT(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .src_empty        (src_empty),
    .src_almost_empty (src_almost_empty),
    .src_frame_ready  (src_frame_ready),
    .src_data         (src_data),
    .src_last         (src_last),
    .src_rd           (src_rd),
    .m_tdata          (m_tdata),
    .m_tvalid         (m_tvalid),
    .m_tlast          (m_tlast),
    .m_tuser          (m_tuser),
    .m_tsrc           (m_tsrc),
    .m_tready         (m_tready),
    .underrun_pulse   (underrun_pulse)
  );

  typedef struct {
    logic       tr;
    logic [3:0] rd;
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       u;
    logic [1:0] s;
    logic       p;
  } vec_t;

  logic [8:0]  q [NS][$];   // {last, data} per source FIFO
  logic [NS-1:0] fr;
  logic [NS-1:0] rd_s;
  logic [11:0] got [$];     // {user, last, src, data} of accepted words
  logic [11:0] exq [$];
  int n_vec = 0, n_bad = 0, cyc = 0, n_pulse = 0;

  function automatic logic [11:0] w(input logic u, input logic l, input logic [1:0] s,
                                    input logic [7:0] d);
    return {u, l, s, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got_v, exp_v, cyc);
    end
  endtask

  task automatic check_words(input string name);
    chk({name, "_count"}, 32'(got.size()), 32'(exq.size()));
    for (int i = 0; i < exq.size(); i++)
      chk(name, 32'((i < got.size()) ? got[i] : 12'hfff), 32'(exq[i]));
  endtask

  task automatic drive();
    logic [NS*DW-1:0] d;
    logic [8:0] h;
    d = '0;
    for (int i = 0; i < NS; i++) begin
      src_empty[i]        = (q[i].size() == 0);
      src_almost_empty[i] = (q[i].size() < 3);
      src_last[i]         = 1'b0;
      if (q[i].size() != 0) begin
        h = q[i][0];
        d[i*DW +: DW] = h[7:0];
        src_last[i]   = h[8];
      end
    end
    src_data        = d;
    src_frame_ready = fr;
  endtask

  // One clock: apply last cycle's pops, new stimulus, then sample at negedge.
  task automatic tick(input logic tr, input logic rst_v);
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++)
      if (rd_s[i] && q[i].size() != 0) void'(q[i].pop_front());
    reset_n = rst_v;
    if (!rst_v) for (int i = 0; i < NS; i++) q[i].delete();
    m_tready = tr;
    drive();
    @(negedge clk);
    rd_s = src_rd;
    cyc++;
    if (underrun_pulse) n_pulse++;
    if (m_tvalid && m_tready) got.push_back({m_tuser, m_tlast, m_tsrc, m_tdata});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [10];
    logic tp [10];
    logic [31:0] gv, ev;
    int last_pop, abort_cyc;

    reset_n = 1'b0;
    m_tready = 1'b1;
    fr = '0;
    rd_s = '0;
    drive();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("reset_state", 32'({src_rd, m_tvalid, m_tdata, m_tlast, m_tuser, m_tsrc, underrun_pulse}), 32'd0);

    // Two 3-word frames on sources 0 and 2, cycle-by-cycle expectations.
    vt[0] = '{1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[1] = '{1'b1, 4'b0001, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[2] = '{1'b1, 4'b0001, 1'b1, 8'h10, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[3] = '{1'b1, 4'b0001, 1'b1, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[4] = '{1'b1, 4'b0000, 1'b1, 8'h12, 1'b1, 1'b0, 2'd0, 1'b0};
    vt[5] = '{1'b1, 4'b0100, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[6] = '{1'b1, 4'b0100, 1'b1, 8'h20, 1'b0, 1'b0, 2'd2, 1'b0};
    vt[7] = '{1'b1, 4'b0100, 1'b1, 8'h21, 1'b0, 1'b0, 2'd2, 1'b0};
    vt[8] = '{1'b1, 4'b0000, 1'b1, 8'h22, 1'b1, 1'b0, 2'd2, 1'b0};
    vt[9] = '{1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
    q[0].push_back(9'h010); q[0].push_back(9'h011); q[0].push_back(9'h112);
    q[2].push_back(9'h020); q[2].push_back(9'h021); q[2].push_back(9'h122);
    fr = 4'b0101;
    for (int v = 0; v < 10; v++) begin
      tick(vt[v].tr, 1'b1);
      gv = 32'({src_rd, m_tvalid,
                vt[v].v ? {m_tdata, m_tlast, m_tuser, m_tsrc} : 12'h000, underrun_pulse});
      ev = 32'({vt[v].rd, vt[v].v,
                vt[v].v ? {vt[v].d, vt[v].l, vt[v].u, vt[v].s} : 12'h000, vt[v].p});
      chk("table_vec", gv, ev);
    end

    // Source 1 holds a partial-looking backlog: not eligible until frame_ready.
    got.delete();
    fr = '0;
    q[1].push_back(9'h080); q[1].push_back(9'h181);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1);
      chk("not_eligible_rd", 32'(src_rd), 32'd0);
    end
    fr[1] = 1'b1;
    tick(1'b1, 1'b1);
    chk("grant_wait_rd", 32'(src_rd), 32'd0);
    tick(1'b1, 1'b1);
    chk("grant_src1_rd", 32'(src_rd), 32'b0010);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
    exq = '{w(1'b0, 1'b0, 2'd1, 8'h80), w(1'b0, 1'b1, 2'd1, 8'h81)};
    check_words("src1_frame");

    // Back-pressure during a 4-word frame from source 3.
    got.delete();
    fr = 4'b1000;
    q[3].push_back(9'h040); q[3].push_back(9'h041); q[3].push_back(9'h042); q[3].push_back(9'h143);
    tp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      tick(tp[i], 1'b1);
      if (!tp[i]) begin
        chk("stall_hold", 32'({m_tvalid, m_tdata, m_tlast, m_tuser, m_tsrc}),
            32'({1'b1, 8'h41, 1'b0, 1'b0, 2'd3}));
        chk("stall_rd", 32'(src_rd), 32'd0);
      end
    end
    exq = '{w(1'b0, 1'b0, 2'd3, 8'h40), w(1'b0, 1'b0, 2'd3, 8'h41),
            w(1'b0, 1'b0, 2'd3, 8'h42), w(1'b0, 1'b1, 2'd3, 8'h43)};
    check_words("stall_frame");

    // Underrun: 2 of 5 words, then the source stays empty.
    got.delete();
    n_pulse = 0;
    fr = 4'b0001;
    last_pop = -1;
    abort_cyc = -1;
    q[0].push_back(9'h050); q[0].push_back(9'h051);
    for (int i = 0; i < 30; i++) begin
      tick(1'b1, 1'b1);
      if (rd_s[0]) last_pop = cyc;
      if (m_tvalid && m_tuser && abort_cyc < 0) abort_cyc = cyc;
    end
    exq = '{w(1'b0, 1'b0, 2'd0, 8'h50), w(1'b0, 1'b0, 2'd0, 8'h51), w(1'b1, 1'b1, 2'd0, 8'h00)};
    check_words("underrun_frame");
    chk("abort_delay", 32'(abort_cyc - last_pop), 32'd18);
    chk("pulse_count", 32'(n_pulse), 32'd1);

    // Late remainder of the aborted frame is flushed without output.
    got.delete();
    q[0].push_back(9'h052); q[0].push_back(9'h053); q[0].push_back(9'h154);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    chk("drain_no_output", 32'(got.size()), 32'd0);
    chk("drain_emptied", 32'(q[0].size()), 32'd0);
    q[0].push_back(9'h155);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
    exq = '{w(1'b0, 1'b1, 2'd0, 8'h55)};
    check_words("post_drain");

    // Reset in the middle of a frame from source 2.
    fr = 4'b0100;
    q[2].push_back(9'h090); q[2].push_back(9'h091); q[2].push_back(9'h092); q[2].push_back(9'h193);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    chk("pre_reset_word", 32'({m_tvalid, m_tsrc, m_tdata}), 32'({1'b1, 2'd2, 8'h90}));
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("mid_reset_state", 32'({src_rd, m_tvalid, m_tdata, m_tlast, m_tuser, m_tsrc, underrun_pulse}), 32'd0);

    // All sources busy after reset: strict rotation starting at source 0.
    got.delete();
    exq.delete();
    fr = '1;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NS; i++) begin
        q[i].push_back({1'b1, 4'(i), 4'(f)});
        exq.push_back(w(1'b0, 1'b1, 2'(i), {4'(i), 4'(f)}));
      end
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b1);
    check_words("rr_order");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Frame-granular round-robin scheduler that drains NUM_SRC first-word-fall-through async-FIFO read ports into one AXI-Stream-style output feeding the Ethernet MAC TX path. It holds a grant for a whole frame, starts a frame only when the source has buffered enough data, and detects mid-frame underrun. On underrun it terminates the frame with an error flag and flushes the rest of that frame from the source FIFO. It runs entirely in the FIFOs' read clock domain.

## Interface
- NUM_SRC, 4, number of source FIFOs (2..8)
- DATA_WIDTH, 8, word width
- UNDERRUN_TIMEOUT, 16, consecutive empty cycles mid-frame before abort (1..255)
- clk  in  1  read-domain clock
- reset_n  in  1  reset, synchronous, active-low
- src_empty  in  NUM_SRC  per-source FIFO empty
- src_almost_empty  in  NUM_SRC  per-source FIFO almost empty
- src_frame_ready  in  NUM_SRC  source holds at least one complete frame
- src_data  in  NUM_SRC*DATA_WIDTH  head word, FWFT, valid when !src_empty; source i at [i*DATA_WIDTH +: DATA_WIDTH]
- src_last  in  NUM_SRC  head word is end of frame
- src_rd  out  NUM_SRC  pop strobe, one-hot or zero
- m_tdata  out  DATA_WIDTH  output word
- m_tvalid  out  1  output valid
- m_tlast  out  1  end of frame
- m_tuser  out  1  frame aborted (underrun), valid with m_tlast
- m_tsrc  out  $clog2(NUM_SRC)  source index of current word
- m_tready  in  1  downstream accept
- underrun_pulse  out  1  one-cycle pulse per aborted frame

## Operation
- States: IDLE, XFER, DRAIN.
- Eligibility: source i is eligible when !src_empty[i] && (src_frame_ready[i] || !src_almost_empty[i]).
- IDLE: if any source is eligible, grant the first eligible index searching from last_grant+1 modulo NUM_SRC; register grant and last_grant; go to XFER. After reset last_grant = NUM_SRC-1, so source 0 has first priority.
- Output register: one stage. It may load when !m_tvalid || m_tready (load_ok). m_tvalid clears when m_tready is high and no new load occurs.
- XFER: when !src_empty[g] && load_ok, assert src_rd[g]. Load m_tdata=src_data[g], m_tlast=src_last[g], m_tuser=0, m_tsrc=g. If src_last[g], go to IDLE.
- Underrun counter: increments each XFER cycle in which src_empty[g] is high. It clears on every pop and on entry to XFER. When it reaches UNDERRUN_TIMEOUT and load_ok is high, load m_tdata=0, m_tlast=1, m_tuser=1; pulse underrun_pulse; go to DRAIN. This takes priority over a pop in the same cycle.
- DRAIN: assert src_rd[g] whenever !src_empty[g], discarding the data; nothing is loaded to the output. On popping a word with src_last[g], go to IDLE. DRAIN has no timeout.
- src_rd is never asserted when the selected src_empty is high, and never asserted in IDLE.

## Timing
- Reset values: src_rd=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, m_tsrc=0, underrun_pulse=0, state=IDLE, counter=0.
- Latency: source becomes eligible in cycle N → grant registered at N+1 → first src_rd at N+1 → m_tvalid at N+2.
- Throughput: one word per cycle while the source is non-empty and m_tready=1. There is a one-cycle IDLE bubble between frames.
- Back-pressure: m_tready=0 with m_tvalid=1 holds all m_* outputs stable and suppresses src_rd.
- m_tready low does not advance the underrun counter unless src_empty[g] is also high. The abort word waits for load_ok.
- Single-word frame (src_last on the first word) returns to IDLE after one pop.
- Reset mid-frame: the block returns immediately to reset values. The source FIFOs share reset_n and are flushed with it.

## Structure
- Package tx_sched_pkg: state enum type (IDLE, XFER, DRAIN) and the NUM_SRC-independent counter width constant.
- Sub-module rr_arbiter: combinational round-robin pick over a request vector plus a last_grant input; outputs grant index and a grant-valid bit. The top level registers last_grant.

## Test plan
- Sources 0 and 2 each hold a 3-word frame with frame_ready=1, m_tready=1 → src0 words, then src2 words; m_tsrc 0,0,0,2,2,2; one idle cycle between frames; m_tlast on words 3 and 6.
- All four sources continuously ready → grant order 0,1,2,3,0 by frame; no source is granted twice in a row.
- Source 1 has 2 words, frame_ready=0, almost_empty=1 → not granted. Raising frame_ready → granted on the next cycle.
- m_tready toggles 1,0,0,1 during a 4-word frame → outputs held while stalled; no src_rd while stalled; all 4 words delivered in order.
- Source 0 empties after 2 of 5 words for 16 cycles → abort word with m_tdata=0, m_tlast=1, m_tuser=1; one underrun_pulse. Refilling the 3 remaining words (last on the 3rd) → all are popped without output, then IDLE.
- reset_n low mid-frame for 1 cycle → all outputs at reset values next cycle; the next grant goes to source 0.
